alu_exec_sequencer: RTL and testbench

- Multi-cycle controller that accepts one RV32 ALU instruction at a time (R-type opcode 0110011, I-type opcode 0010011).
- Owns the 32x32 integer register file and decodes the instruction into op1/op2/aluop.
- Issues the operation to an external ALU over a req/ack handshake, then writes the result back to rd.
- Sits between the instruction source and the shared ALU. It is the sequencing and writeback layer for the decode datapath.

---
 rtl/alu_exec_sequencer_pkg.sv | 25 ++
 rtl/alu_exec_sequencer_decode.sv | 46 ++++
 rtl/alu_exec_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_exec_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_sequencer_pkg.sv
// Shared encodings for the ALU execution sequencer: opcodes, ALU op codes, FSM states.
package alu_exec_sequencer_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [3:0] ALUOP_ADD  = 4'b0000;
  localparam logic [3:0] ALUOP_SUB  = 4'b1000;
  localparam logic [3:0] ALUOP_SLL  = 4'b0001;
  localparam logic [3:0] ALUOP_SLT  = 4'b0010;
  localparam logic [3:0] ALUOP_SLTU = 4'b0011;
  localparam logic [3:0] ALUOP_XOR  = 4'b0100;
  localparam logic [3:0] ALUOP_SRL  = 4'b0101;
  localparam logic [3:0] ALUOP_SRA  = 4'b1101;
  localparam logic [3:0] ALUOP_OR   = 4'b0110;
  localparam logic [3:0] ALUOP_AND  = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ISSUE,
    ST_WB
  } state_e;

endpackage

// File: rtl/alu_exec_sequencer_decode.sv
// Combinational RV32 R/I-type ALU decoder: register fields, immediate, ALU op, legality.
module alu_ins_decode
  import alu_exec_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ins,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm_sext,
  output logic            is_r,
  output logic [3:0]      alu_op,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode   = ins[6:0];
  assign rd       = ins[11:7];
  assign funct3   = ins[14:12];
  assign rs1      = ins[19:15];
  assign rs2      = ins[24:20];
  assign funct7   = ins[31:25];
  assign imm_sext = {{(XLEN-12){ins[31]}}, ins[31:20]};
  assign is_r     = (opcode == OP_R);
  assign alu_op   = is_r ? {funct7[5], funct3} : {1'b0, funct3};

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0100000)
          illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
        else
          illegal = (funct7 != 7'b0000000);
      end
      // Immediate shifts are not supported by this sequencer.
      OP_I:    illegal = (funct3 == 3'b001 || funct3 == 3'b101);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// One-at-a-time RV32 ALU instruction sequencer: decode, issue to external ALU, write back.
module alu_exec_sequencer
  import alu_exec_sequencer_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic [31:0]      ins,
  output logic             alu_req,
  output logic [XLEN-1:0]  alu_op1,
  output logic [XLEN-1:0]  alu_op2,
  output logic [3:0]       alu_op,
  input  logic             alu_ack,
  input  logic [XLEN-1:0]  alu_result,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             illegal,
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] retired,
  input  logic [4:0]       dbg_addr,
  output logic [XLEN-1:0]  dbg_data
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  state_e            state;
  logic [31:0]       ins_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [XLEN-1:0]   rf [32];

  logic [4:0]        dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_is_r, dec_illegal;
  logic [3:0]        dec_op;

  alu_ins_decode #(.XLEN(XLEN)) u_dec (
    .ins      (ins_q),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .imm_sext (dec_imm),
    .is_r     (dec_is_r),
    .alu_op   (dec_op),
    .illegal  (dec_illegal)
  );

  assign ins_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign dbg_data  = rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ins_q    <= '0;
      wait_cnt <= '0;
      alu_req  <= 1'b0;
      alu_op1  <= '0;
      alu_op2  <= '0;
      alu_op   <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      retired  <= '0;
    end else begin
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ins_valid) begin
            ins_q <= ins;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_illegal) begin
            illegal <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            alu_op1  <= rf[dec_rs1];
            alu_op2  <= dec_is_r ? rf[dec_rs2] : dec_imm;
            alu_op   <= dec_op;
            alu_req  <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // An ack on the last allowed cycle still wins over the timeout.
          if (alu_ack) begin
            alu_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= dec_rd;
            wb_data  <= alu_result;
            state    <= ST_WB;
          end else if (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1)) begin
            alu_req <= 1'b0;
            timeout <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WB: begin
          retired <= retired + 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // x0 holds its reset value of zero because it is never a write target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= XLEN'(2 * i);
    end else if (state == ST_WB && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with hand-computed expectations.
module tb_alu_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic        alu_req;
  logic [31:0] alu_op1, alu_op2;
  logic [3:0]  alu_op;
  logic        alu_ack;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal, timeout, busy;
  logic [15:0] retired;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  alu_exec_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins        (ins),
    .alu_req    (alu_req),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_op     (alu_op),
    .alu_ack    (alu_ack),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .illegal    (illegal),
    .timeout    (timeout),
    .busy       (busy),
    .retired    (retired),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered just after a clock edge with the DUT idle; the offer cycle is cycle 0.
  task automatic do_ins(input string tag, input logic [31:0] iw,
                        input logic [31:0] e1, input logic [31:0] e2, input logic [3:0] eop,
                        input logic [31:0] res, input logic [4:0] erd,
                        input logic [31:0] e_pre, input logic [31:0] e_post);
    dbg_addr = erd;
    chk({tag, ".ready0"}, 32'(ins_ready), 1);
    ins_valid = 1'b1; ins = iw;
    tick();                                   // cycle 1: DECODE
    ins_valid = 1'b0; ins = '0;
    chk({tag, ".busy1"}, 32'(busy), 1);
    chk({tag, ".req1"}, 32'(alu_req), 0);
    tick();                                   // cycle 2: ISSUE, ack immediately
    chk({tag, ".req2"}, 32'(alu_req), 1);
    chk({tag, ".op1"}, alu_op1, e1);
    chk({tag, ".op2"}, alu_op2, e2);
    chk({tag, ".aluop"}, 32'(alu_op), 32'(eop));
    alu_ack = 1'b1; alu_result = res;
    tick();                                   // cycle 3: WB
    alu_ack = 1'b0; alu_result = '0;
    chk({tag, ".wbv3"}, 32'(wb_valid), 1);
    chk({tag, ".wbrd"}, 32'(wb_rd), 32'(erd));
    chk({tag, ".wbdata"}, wb_data, res);
    chk({tag, ".req3"}, 32'(alu_req), 0);
    chk({tag, ".dbgpre"}, dbg_data, e_pre);
    tick();                                   // cycle 4: IDLE again
    chk({tag, ".wbv4"}, 32'(wb_valid), 0);
    chk({tag, ".ready4"}, 32'(ins_ready), 1);
    chk({tag, ".dbgpost"}, dbg_data, e_post);
  endtask

  task automatic do_illegal(input string tag, input logic [31:0] iw, input logic [15:0] eret);
    ins_valid = 1'b1; ins = iw;
    tick();                                   // DECODE
    ins_valid = 1'b0; ins = '0;
    chk({tag, ".req"}, 32'(alu_req), 0);
    tick();                                   // back in IDLE with illegal pulse
    chk({tag, ".ill"}, 32'(illegal), 1);
    chk({tag, ".req_b"}, 32'(alu_req), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".wbv"}, 32'(wb_valid), 0);
    tick();
    chk({tag, ".ill_off"}, 32'(illegal), 0);
    chk({tag, ".ret"}, 32'(retired), 32'(eret));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; ins_valid = 1'b0; ins = '0;
    alu_ack = 1'b0; alu_result = '0; dbg_addr = 5'd5;

    // 1. reset state
    #12;
    chk("rst.req", 32'(alu_req), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.ret", 32'(retired), 0);
    chk("rst.op1", alu_op1, 0);
    chk("rst.wbv", 32'(wb_valid), 0);
    chk("rst.dbg5", dbg_data, 32'd10);
    rst_n = 1'b1;
    tick();
    chk("rst.ready", 32'(ins_ready), 1);

    // 2. add x3,x1,x2
    do_ins("add3", 32'h002081B3, 32'd2, 32'd4, 4'b0000, 32'd6, 5'd3, 32'd6, 32'd6);
    chk("add3.ret", 32'(retired), 1);

    // 3. addi x4,x2,-1 ; sub x5,x6,x7 ; dependent add x8,x4,x4
    do_ins("addi4", 32'hFFF10213, 32'd4, 32'hFFFFFFFF, 4'b0000, 32'd3, 5'd4, 32'd8, 32'd3);
    do_ins("sub5", 32'h407302B3, 32'd12, 32'd14, 4'b1000, 32'hFFFFFFFE, 5'd5, 32'd10, 32'hFFFFFFFE);
    do_ins("dep8", 32'h00420433, 32'd3, 32'd3, 4'b0000, 32'd6, 5'd8, 32'd16, 32'd6);
    chk("dep8.ret", 32'(retired), 4);

    // 4. illegal encodings
    do_illegal("jal", 32'h0000006F, 16'd4);
    do_illegal("slli", 32'h00109093, 16'd4);
    do_illegal("rf7", 32'h400091B3, 16'd4);

    // 5. write to x0
    do_ins("add0", 32'h00208033, 32'd2, 32'd4, 4'b0000, 32'd6, 5'd0, 32'd0, 32'd0);
    chk("add0.ret", 32'(retired), 5);
    do_ins("add3b", 32'h002081B3, 32'd2, 32'd4, 4'b0000, 32'h55, 5'd3, 32'd6, 32'h55);
    chk("add3b.ret", 32'(retired), 6);

    // 6a. no ack: timeout after 15 request cycles
    dbg_addr = 5'd3;
    ins_valid = 1'b1; ins = 32'h002081B3;
    tick();
    ins_valid = 1'b0; ins = '0;
    tick();
    n = 0;
    while (alu_req && n < 40) begin
      n++;
      tick();
    end
    chk("to.cycles", 32'(n), 32'd15);
    chk("to.pulse", 32'(timeout), 1);
    chk("to.busy", 32'(busy), 0);
    tick();
    chk("to.pulse_off", 32'(timeout), 0);
    chk("to.wbv", 32'(wb_valid), 0);
    chk("to.reg3", dbg_data, 32'h55);
    chk("to.ret", 32'(retired), 6);

    // 6b. reset mid-ISSUE
    ins_valid = 1'b1; ins = 32'h002081B3;
    tick();
    ins_valid = 1'b0; ins = '0;
    tick();
    tick();
    chk("mr.req_pre", 32'(alu_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr.req", 32'(alu_req), 0);
    chk("mr.busy", 32'(busy), 0);
    chk("mr.reg3", dbg_data, 32'd6);
    chk("mr.ret", 32'(retired), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mr.ready", 32'(ins_ready), 1);
    chk("mr.req_after", 32'(alu_req), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
